// File: rtl/motor_ctrl_pkg.sv
// Shared types and helpers for the multi-drive spindle motor controller.
package motor_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_OFF        = 3'd0,
    ST_WAIT_GRANT = 3'd1,
    ST_SPINUP     = 3'd2,
    ST_AT_SPEED   = 3'd3,
    ST_SPINDOWN   = 3'd4
  } motor_state_e;

  localparam logic [7:0] REV_SAT = 8'hFF;

  function automatic longint unsigned ms_to_cycles(input longint unsigned clk_hz,
                                                   input longint unsigned ms);
    return (clk_hz / 64'd1000) * ms;
  endfunction

endpackage

// File: rtl/motor_channel.sv
// One drive channel: spinup/at-speed/spindown FSM with timers, revolution
// counters, idle auto-off and the re-command lockout bit.
module motor_channel
  import motor_ctrl_pkg::*;
#(
  parameter int unsigned         TIMER_W      = 32,
  parameter int unsigned         IDLE_W       = 4,
  parameter int unsigned         SPINUP_REVS  = 3,
  parameter logic [TIMER_W-1:0]  SPINUP_CYC   = '0,
  parameter logic [TIMER_W-1:0]  SPINDOWN_CYC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_i,
  input  logic              index_i,
  input  logic              active_i,
  input  logic              auto_off_en_i,
  input  logic [IDLE_W-1:0] idle_revs_i,
  input  logic              grant_i,
  output logic              pending_o,
  output logic              spinup_o,
  output logic              enable_o,
  output logic              running_o,
  output logic              at_speed_o,
  output logic              auto_off_o,
  output logic [7:0]        rev_count_o
);

  localparam int unsigned IDX_W = 8;

  motor_state_e       state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDLE_W-1:0]  idle_q, idle_d;
  logic [7:0]         rev_q, rev_d;
  logic               lock_q, lock_d;
  logic               idle_armed;
  logic               fire;

  assign idle_armed = auto_off_en_i && (idle_revs_i != '0);

  // A dropped command outranks auto-off, so fire is qualified by cmd_i.
  assign fire = (state_q == ST_AT_SPEED) && cmd_i && idle_armed && index_i && !active_i &&
                ((IDLE_W+1)'(idle_q) + (IDLE_W+1)'(1) >= (IDLE_W+1)'(idle_revs_i));

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    idx_d   = idx_q;
    idle_d  = idle_q;
    rev_d   = rev_q;
    lock_d  = lock_q;

    if (!cmd_i) begin
      lock_d = 1'b0;
    end else if (fire) begin
      lock_d = 1'b1;
    end

    unique case (state_q)
      ST_OFF: begin
        rev_d  = '0;
        idle_d = '0;
        if (cmd_i && !lock_q) state_d = ST_WAIT_GRANT;
      end
      ST_WAIT_GRANT: begin
        if (!cmd_i) begin
          state_d = ST_OFF;
        end else if (grant_i) begin
          state_d = ST_SPINUP;
          timer_d = SPINUP_CYC;
          idx_d   = '0;
        end
      end
      ST_SPINUP: begin
        if (!cmd_i) begin
          state_d = ST_SPINDOWN;
          timer_d = SPINDOWN_CYC;
        end else if ((index_i && idx_q == IDX_W'(SPINUP_REVS - 1)) || timer_q == '0) begin
          state_d = ST_AT_SPEED;
          idle_d  = '0;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
          if (index_i) idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_AT_SPEED: begin
        if (index_i && rev_q != REV_SAT) rev_d = rev_q + 8'd1;
        if (idle_armed) begin
          if (active_i)     idle_d = '0;
          else if (index_i) idle_d = idle_q + IDLE_W'(1);
        end
        if (!cmd_i || fire) begin
          state_d = ST_SPINDOWN;
          timer_d = SPINDOWN_CYC;
        end
      end
      ST_SPINDOWN: begin
        if (cmd_i && !lock_q) begin
          state_d = ST_WAIT_GRANT;
        end else if (timer_q == '0) begin
          state_d = ST_OFF;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      default: state_d = ST_OFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_OFF;
      timer_q <= '0;
      idx_q   <= '0;
      idle_q  <= '0;
      rev_q   <= '0;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      idle_q  <= idle_d;
      rev_q   <= rev_d;
      lock_q  <= lock_d;
    end
  end

  assign pending_o   = (state_q == ST_WAIT_GRANT);
  assign spinup_o    = (state_q == ST_SPINUP);
  assign enable_o    = (state_q == ST_SPINUP) || (state_q == ST_AT_SPEED);
  assign running_o   = (state_q == ST_SPINUP) || (state_q == ST_AT_SPEED) ||
                       (state_q == ST_SPINDOWN);
  assign at_speed_o  = (state_q == ST_AT_SPEED);
  assign auto_off_o  = fire;
  assign rev_count_o = rev_q;

endmodule

// File: rtl/motor_controller_multi.sv
// N-drive motor controller: per-drive channels plus a spinup arbiter that
// optionally serialises spinups to limit inrush on the shared 12V rail.
module motor_controller_multi
  import motor_ctrl_pkg::*;
#(
  parameter int unsigned NUM_DRIVES  = 4,
  parameter int unsigned CLK_HZ      = 200_000_000,
  parameter int unsigned SPINUP_MS   = 500,
  parameter int unsigned SPINDOWN_MS = 2000,
  parameter int unsigned SPINUP_REVS = 3,
  parameter int unsigned IDLE_W      = 4,
  parameter int unsigned STAGGER     = 1,
  parameter int unsigned TIMER_W     = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_DRIVES-1:0]   motor_on_cmd,
  input  logic [NUM_DRIVES-1:0]   index_pulse,
  input  logic [NUM_DRIVES-1:0]   drive_active,
  input  logic                    auto_off_enable,
  input  logic [IDLE_W-1:0]       idle_revs,
  output logic [NUM_DRIVES-1:0]   motor_enable,
  output logic [NUM_DRIVES-1:0]   motor_running,
  output logic [NUM_DRIVES-1:0]   motor_at_speed,
  output logic [NUM_DRIVES-1:0]   spinup_pending,
  output logic [NUM_DRIVES-1:0]   auto_off_event,
  output logic [8*NUM_DRIVES-1:0] rev_count
);

  localparam longint unsigned SPINUP_FULL   = ms_to_cycles(64'(CLK_HZ), 64'(SPINUP_MS));
  localparam longint unsigned SPINDOWN_FULL = ms_to_cycles(64'(CLK_HZ), 64'(SPINDOWN_MS));
  localparam longint unsigned TIMER_LIMIT   = 64'd1 << TIMER_W;
  localparam logic [TIMER_W-1:0] SPINUP_CYC   = TIMER_W'(SPINUP_FULL);
  localparam logic [TIMER_W-1:0] SPINDOWN_CYC = TIMER_W'(SPINDOWN_FULL);

  if (NUM_DRIVES < 1 || NUM_DRIVES > 8) begin : g_bad_drives
    $error("NUM_DRIVES must be in 1..8");
  end
  if (TIMER_W < 1 || TIMER_W > 63) begin : g_bad_timer_w
    $error("TIMER_W must be in 1..63");
  end
  if (SPINUP_REVS < 1 || SPINUP_REVS > 256) begin : g_bad_revs
    $error("SPINUP_REVS must be in 1..256");
  end
  if (SPINUP_FULL >= TIMER_LIMIT || SPINDOWN_FULL >= TIMER_LIMIT) begin : g_timer_ovf
    $error("spinup/spindown cycle count overflows TIMER_W");
  end

  logic [NUM_DRIVES-1:0] pending;
  logic [NUM_DRIVES-1:0] in_spinup;
  logic [NUM_DRIVES-1:0] grant;

  // Lowest set bit of pending via two's-complement isolate.
  always_comb begin
    grant = '0;
    if (STAGGER == 0) begin
      grant = pending;
    end else if (in_spinup == '0) begin
      grant = pending & (~pending + NUM_DRIVES'(1));
    end
  end

  for (genvar i = 0; i < NUM_DRIVES; i++) begin : g_ch
    motor_channel #(
      .TIMER_W      (TIMER_W),
      .IDLE_W       (IDLE_W),
      .SPINUP_REVS  (SPINUP_REVS),
      .SPINUP_CYC   (SPINUP_CYC),
      .SPINDOWN_CYC (SPINDOWN_CYC)
    ) u_ch (
      .clk           (clk),
      .reset         (reset),
      .cmd_i         (motor_on_cmd[i]),
      .index_i       (index_pulse[i]),
      .active_i      (drive_active[i]),
      .auto_off_en_i (auto_off_enable),
      .idle_revs_i   (idle_revs),
      .grant_i       (grant[i]),
      .pending_o     (pending[i]),
      .spinup_o      (in_spinup[i]),
      .enable_o      (motor_enable[i]),
      .running_o     (motor_running[i]),
      .at_speed_o    (motor_at_speed[i]),
      .auto_off_o    (auto_off_event[i]),
      .rev_count_o   (rev_count[8*i +: 8])
    );
  end

  assign spinup_pending = pending;

endmodule

// File: tb/tb_motor_controller_multi.sv
// Scoreboard bench: stimulus pushes per-cycle expected outputs from a
// reference model; an independent monitor pops and compares each cycle.
module tb_motor_controller_multi;

  localparam int ND = 4;
  localparam int SPINUP_CYC   = 50;
  localparam int SPINDOWN_CYC = 20;
  localparam int UP_REVS      = 3;

  logic            clk;
  logic            reset;
  logic [ND-1:0]   motor_on_cmd, index_pulse, drive_active;
  logic            auto_off_enable;
  logic [3:0]      idle_revs;
  logic [ND-1:0]   motor_enable, motor_running, motor_at_speed, spinup_pending, auto_off_event;
  logic [8*ND-1:0] rev_count;

  motor_controller_multi #(
    .NUM_DRIVES  (ND),
    .CLK_HZ      (1000),
    .SPINUP_MS   (50),
    .SPINDOWN_MS (20),
    .SPINUP_REVS (3),
    .IDLE_W      (4),
    .STAGGER     (1),
    .TIMER_W     (32)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .motor_on_cmd    (motor_on_cmd),
    .index_pulse     (index_pulse),
    .drive_active    (drive_active),
    .auto_off_enable (auto_off_enable),
    .idle_revs       (idle_revs),
    .motor_enable    (motor_enable),
    .motor_running   (motor_running),
    .motor_at_speed  (motor_at_speed),
    .spinup_pending  (spinup_pending),
    .auto_off_event  (auto_off_event),
    .rev_count       (rev_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [ND-1:0]   en, run, spd, pend, evt;
    logic [8*ND-1:0] rev;
  } obs_t;

  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: a drive is idle, queued for the spinup slot, ramping
  // (counting elapsed cycles and index pulses up), running, or coasting.
  typedef enum int {M_IDLE, M_QUEUED, M_RAMP, M_RUN, M_COAST} mode_e;
  mode_e mode  [ND];
  int    ramp_t[ND], ramp_ix[ND], coast_t[ND], idle_n[ND], revs[ND];
  bit    locked[ND];

  logic [ND-1:0] cmd_r, act_r;
  logic          aoe_r;
  logic [3:0]    ir_r;

  function automatic bit model_fire(int d, logic [ND-1:0] ix);
    return mode[d] == M_RUN && cmd_r[d] && aoe_r && ir_r != 0 && ix[d] && !act_r[d] &&
           idle_n[d] + 1 >= int'(ir_r);
  endfunction

  function automatic obs_t model_obs(logic [ND-1:0] ix);
    obs_t o;
    o = '0;
    for (int d = 0; d < ND; d++) begin
      o.en[d]        = mode[d] == M_RAMP || mode[d] == M_RUN;
      o.run[d]       = mode[d] != M_IDLE && mode[d] != M_QUEUED;
      o.spd[d]       = mode[d] == M_RUN;
      o.pend[d]      = mode[d] == M_QUEUED;
      o.evt[d]       = model_fire(d, ix);
      o.rev[8*d +: 8] = 8'(revs[d]);
    end
    return o;
  endfunction

  task automatic model_step(logic [ND-1:0] ix, logic rs);
    logic [ND-1:0] grant;
    bit ramping;
    bit fire;
    grant   = '0;
    ramping = 0;
    for (int d = 0; d < ND; d++) if (mode[d] == M_RAMP) ramping = 1;
    if (!ramping)
      for (int d = 0; d < ND; d++)
        if (mode[d] == M_QUEUED) begin grant[d] = 1'b1; break; end
    for (int d = 0; d < ND; d++) begin
      if (rs) begin
        mode[d] = M_IDLE; ramp_t[d] = 0; ramp_ix[d] = 0; coast_t[d] = 0;
        idle_n[d] = 0; revs[d] = 0; locked[d] = 0;
        continue;
      end
      fire = model_fire(d, ix);
      case (mode[d])
        M_IDLE: begin
          revs[d] = 0; idle_n[d] = 0;
          if (cmd_r[d] && !locked[d]) mode[d] = M_QUEUED;
        end
        M_QUEUED: begin
          if (!cmd_r[d]) mode[d] = M_IDLE;
          else if (grant[d]) begin mode[d] = M_RAMP; ramp_t[d] = 0; ramp_ix[d] = 0; end
        end
        M_RAMP: begin
          if (!cmd_r[d]) begin mode[d] = M_COAST; coast_t[d] = 0; end
          else if ((ix[d] && ramp_ix[d] + 1 == UP_REVS) || ramp_t[d] == SPINUP_CYC) begin
            mode[d] = M_RUN; idle_n[d] = 0;
          end else begin
            ramp_t[d]++;
            if (ix[d]) ramp_ix[d]++;
          end
        end
        M_RUN: begin
          if (ix[d] && revs[d] < 255) revs[d]++;
          if (aoe_r && ir_r != 0) begin
            if (act_r[d]) idle_n[d] = 0;
            else if (ix[d]) idle_n[d]++;
          end
          if (!cmd_r[d] || fire) begin mode[d] = M_COAST; coast_t[d] = 0; end
        end
        default: begin
          if (cmd_r[d] && !locked[d]) mode[d] = M_QUEUED;
          else if (coast_t[d] == SPINDOWN_CYC) mode[d] = M_IDLE;
          else coast_t[d]++;
        end
      endcase
      if (!cmd_r[d]) locked[d] = 0;
      else if (fire) locked[d] = 1;
    end
  endtask

  task automatic step(logic [ND-1:0] ix, logic rs);
    @(negedge clk);
    motor_on_cmd    = cmd_r;
    drive_active    = act_r;
    auto_off_enable = aoe_r;
    idle_revs       = ir_r;
    index_pulse     = ix;
    reset           = rs;
    exp_q.push_back(model_obs(ix));
    model_step(ix, rs);
  endtask

  task automatic chk(string name, logic [31:0] got, logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  // Monitor: outputs are presented every cycle; compare mid-low-phase.
  initial begin
    obs_t e, got;
    forever begin
      @(negedge clk);
      #2;
      got = '{en: motor_enable, run: motor_running, spd: motor_at_speed,
              pend: spinup_pending, evt: auto_off_event, rev: rev_count};
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (got !== e) begin
          n_bad++;
          $display("FAIL outputs@%0t: got en=%h run=%h spd=%h pend=%h evt=%h rev=%h, required en=%h run=%h spd=%h pend=%h evt=%h rev=%h",
                   $time, got.en, got.run, got.spd, got.pend, got.evt, got.rev,
                   e.en, e.run, e.spd, e.pend, e.evt, e.rev);
        end
        n_cmp++;
        if ($countones(motor_enable & ~motor_at_speed) > 1) begin
          n_bad++;
          $display("FAIL one_spinup@%0t: got spinning-up mask %b, required at most one bit", $time,
                   motor_enable & ~motor_at_speed);
        end
      end
    end
  end

  initial begin
    cmd_r = '0; act_r = '0; aoe_r = 1'b0; ir_r = '0;
    motor_on_cmd = '0; index_pulse = '0; drive_active = '0;
    auto_off_enable = 1'b0; idle_revs = '0; reset = 1'b1;
    for (int d = 0; d < ND; d++) begin
      mode[d] = M_IDLE; ramp_t[d] = 0; ramp_ix[d] = 0; coast_t[d] = 0;
      idle_n[d] = 0; revs[d] = 0; locked[d] = 0;
    end
    @(posedge clk);
    repeat (3) step('0, 1'b1);
    chk("reset_outputs", {motor_enable, motor_running, spinup_pending, rev_count[15:0]}, '0);

    // Single drive, timeout-based spinup.
    cmd_r = 4'b0001;
    step('0, 1'b0);
    step('0, 1'b0);
    chk("t1_pending", spinup_pending, 4'b0001);
    chk("t1_enable_early", motor_enable, 4'b0000);
    step('0, 1'b0);
    chk("t1_enable", motor_enable, 4'b0001);
    repeat (50) step('0, 1'b0);
    chk("t1_not_yet", motor_at_speed, 4'b0000);
    step('0, 1'b0);
    chk("t1_at_speed", motor_at_speed, 4'b0001);

    // Index-based early at-speed, then revolution counting.
    cmd_r = '0;
    repeat (2) step('0, 1'b1);
    cmd_r = 4'b0001;
    repeat (3) step('0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      repeat (9) step('0, 1'b0);
      step(4'b0001, 1'b0);
    end
    step('0, 1'b0);
    chk("t2_at_speed", motor_at_speed, 4'b0001);
    for (int k = 0; k < 5; k++) begin
      step(4'b0001, 1'b0);
      step('0, 1'b0);
    end
    step('0, 1'b0);
    chk("t2_revs", rev_count[7:0], 8'd5);

    // Idle auto-off, lockout, and re-command.
    aoe_r = 1'b1; ir_r = 4'd2;
    step('0, 1'b0);
    step(4'b0001, 1'b0);
    step('0, 1'b0);
    step(4'b0001, 1'b0);
    #1;
    chk("t4_event", auto_off_event, 4'b0001);
    step('0, 1'b0);
    chk("t4_enable_off", {motor_enable, motor_running}, {4'b0000, 4'b0001});
    repeat (25) step('0, 1'b0);
    chk("t4_locked_off", {motor_running, spinup_pending}, '0);
    cmd_r = '0;
    step('0, 1'b0);
    cmd_r = 4'b0001;
    repeat (3) step('0, 1'b0);
    chk("t4_respin", motor_enable, 4'b0001);
    aoe_r = 1'b0; ir_r = '0;

    // Staggered spinup of all drives.
    cmd_r = '0;
    repeat (2) step('0, 1'b1);
    cmd_r = 4'hF;
    repeat (3) step('0, 1'b0);
    chk("t3_pending", spinup_pending, 4'hE);
    chk("t3_first", motor_enable, 4'h1);
    repeat (250) step('0, 1'b0);
    chk("t3_all_at_speed", motor_at_speed, 4'hF);

    // Re-command mid-spindown, then saturate the revolution counter.
    cmd_r = '0;
    repeat (2) step('0, 1'b1);
    cmd_r = 4'b0010;
    repeat (60) step('0, 1'b0);
    cmd_r = '0;
    repeat (11) step('0, 1'b0);
    cmd_r = 4'b0010;
    step('0, 1'b0);
    step('0, 1'b0);
    chk("t5_regrant", {spinup_pending, motor_at_speed}, {4'b0010, 4'b0000});
    repeat (60) step('0, 1'b0);
    for (int k = 0; k < 300; k++) begin
      step(4'b0010, 1'b0);
      step('0, 1'b0);
    end
    chk("t5_rev_sat", rev_count[15:8], 8'hFF);

    // Reset mid-spinup with command held.
    cmd_r = '0;
    repeat (2) step('0, 1'b1);
    cmd_r = 4'b0100;
    repeat (10) step('0, 1'b0);
    step('0, 1'b1);
    step('0, 1'b0);
    chk("t6_reset_clear", {motor_enable, motor_running, motor_at_speed, spinup_pending}, '0);
    step('0, 1'b0);
    chk("t6_restart", spinup_pending, 4'b0100);

    // Randomised traffic.
    for (int n = 0; n < 3000; n++) begin
      logic [ND-1:0] ix;
      logic rs;
      if ($urandom_range(0, 39) == 0) cmd_r[2'($urandom_range(0, 3))] ^= 1'b1;
      for (int d = 0; d < ND; d++) begin
        act_r[d] = ($urandom_range(0, 7) == 0);
        ix[d]    = ($urandom_range(0, 4) == 0);
      end
      if (n % 200 == 0) begin
        aoe_r = 1'($urandom_range(0, 1));
        ir_r  = 4'($urandom_range(0, 4));
      end
      rs = ($urandom_range(0, 699) == 0);
      if (rs) ix = '0;
      step(ix, rs);
    end

    @(negedge clk);
    #5;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
